// File: rtl/instr_stream_responder.sv
// ============================================================================
// Module   : instr_stream_responder
// Brief    : Responder side of the fetch instruction-stream handshake; delivers
//            one stored word per ack pulse after programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_stream_responder #(
    parameter int IWIDTH      = 32,
    parameter int DEPTH       = 64,
    parameter int AWIDTH      = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic              f_clk,
    input  logic              f_rst,
    input  logic              r_i_syn,
    input  logic              r_i_restart,
    input  logic [AWIDTH:0]   r_i_len,
    input  logic              r_i_wr_en,
    input  logic [AWIDTH-1:0] r_i_wr_addr,
    input  logic [IWIDTH-1:0] r_i_wr_data,
    output logic [IWIDTH-1:0] r_o_instr,
    output logic              r_o_ack,
    output logic              r_o_last,
    output logic              r_o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0]   c_WAIT    = CW'(WAIT_STATES);
    localparam logic [CW-1:0]   c_CNT_ONE = CW'(1);
    localparam logic [AWIDTH:0] c_DEPTH   = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] c_LEN_ONE = (AWIDTH + 1)'(1);

    logic [IWIDTH-1:0] r_mem [0:DEPTH-1];

    logic [1:0]        r_state;
    logic [AWIDTH-1:0] r_addr;
    logic [CW-1:0]     r_cnt;
    logic [AWIDTH:0]   r_len_q;

    logic [1:0]        w_state_nx;
    logic [AWIDTH-1:0] w_addr_nx;
    logic [CW-1:0]     w_cnt_nx;
    logic [AWIDTH:0]   w_len_nx;
    logic [AWIDTH:0]   w_len_clamp;
    logic [AWIDTH:0]   w_len_eff;
    logic [AWIDTH:0]   w_last_idx;
    logic              w_load;
    logic              w_last;
    logic              w_wr_ok;

    assign r_o_busy = (r_state != S_IDLE);
    assign w_wr_ok  = (r_state == S_IDLE) || (r_state == S_DONE);

    // w_load marks the edge that enters SEND; the word read is at the next address.
    always_comb begin
        w_state_nx  = r_state;
        w_addr_nx   = r_addr;
        w_cnt_nx    = r_cnt;
        w_len_nx    = r_len_q;
        w_load      = 1'b0;
        w_len_clamp = (r_i_len > c_DEPTH) ? c_DEPTH : r_i_len;
        w_len_eff   = r_len_q;
        if (r_i_restart) begin
            w_state_nx = S_IDLE;
            w_addr_nx  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_i_syn && (r_i_len != '0)) begin
                        w_len_nx  = w_len_clamp;
                        w_len_eff = w_len_clamp;
                        if (WAIT_STATES == 0) begin
                            w_state_nx = S_SEND;
                            w_load     = 1'b1;
                        end else begin
                            w_state_nx = S_WAIT;
                            w_cnt_nx   = c_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!r_i_syn) begin
                        w_state_nx = S_IDLE;
                    end else if (r_cnt == c_CNT_ONE) begin
                        w_state_nx = S_SEND;
                        w_cnt_nx   = '0;
                        w_load     = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - c_CNT_ONE;
                    end
                end
                S_SEND: begin
                    w_addr_nx = r_addr + 1'b1;
                    if (r_o_last) begin
                        w_state_nx = S_DONE;
                    end else if (r_i_syn) begin
                        if (WAIT_STATES == 0) begin
                            w_state_nx = S_SEND;
                            w_load     = 1'b1;
                        end else begin
                            w_state_nx = S_WAIT;
                            w_cnt_nx   = c_WAIT;
                        end
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    if (!r_i_syn) begin
                        w_state_nx = S_IDLE;
                        w_addr_nx  = '0;
                    end
                end
            endcase
        end
    end

    assign w_last_idx = w_len_eff - c_LEN_ONE;
    assign w_last     = ({1'b0, w_addr_nx} == w_last_idx);

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_len_q   <= '0;
            r_o_instr <= '0;
            r_o_ack   <= 1'b0;
            r_o_last  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_addr   <= w_addr_nx;
            r_cnt    <= w_cnt_nx;
            r_len_q  <= w_len_nx;
            r_o_ack  <= w_load;
            r_o_last <= w_load & w_last;
            if (w_load) begin
                r_o_instr <= r_mem[w_addr_nx];
            end
        end
    end

    // Store is not reset; writes only land while no word is being fetched.
    always_ff @(posedge f_clk) begin
        if (r_i_wr_en && w_wr_ok) begin
            r_mem[r_i_wr_addr] <= r_i_wr_data;
        end
    end

endmodule

`default_nettype wire
